// File: rtl/s2p_pkg.sv
// Shared constants for the serializer/deserializer pair: default word width and FSM state encodings.
package s2p_pkg;

    localparam int S2P_WIDTH = 4;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    // Bit-counter width able to hold the value WIDTH.
    function automatic int s2p_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// One-word holding register with valid/ready handoff and sticky overflow.
// Accepts a word on load when empty or draining this cycle; otherwise the word is dropped.
module s2p_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             out_ready,
    input  logic             clr_overflow,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    output logic             overflow
);

    logic take;
    logic accept;
    logic drop;

    assign take   = out_valid & out_ready;
    assign accept = load & (~out_valid | out_ready);
    assign drop   = load & out_valid & ~out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out_data  <= word;
            out_valid <= 1'b1;
        end else if (take) begin
            out_valid <= 1'b0;
        end
    end

    // Set has priority over a same-cycle clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_to_parallel_4bits.sv
// Reassembles an MSB-first serial stream into WIDTH-bit words; each word begins with start.
// out_valid rises on the edge sampling the last bit; a stalled consumer causes dropped words and overflow.
module serial_to_parallel_4bits
    import s2p_pkg::*;
#(
    parameter int WIDTH = S2P_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    input  logic             clr_overflow
);

    localparam int CNT_W = s2p_cnt_w(WIDTH);

    logic [0:0]       state;
    logic [0:0]       state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [WIDTH-1:0] shifted;
    logic             word_done;

    assign shifted = {sreg[WIDTH-2:0], bit_in};

    // A start with a valid bit always (re)begins a word, whether idle or mid-word.
    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        count_nxt = count;
        word_done = 1'b0;
        if (bit_valid) begin
            if (start) begin
                sreg_nxt  = {{(WIDTH-1){1'b0}}, bit_in};
                count_nxt = CNT_W'(1);
                state_nxt = SHIFT;
            end else if (state == SHIFT) begin
                sreg_nxt = shifted;
                if (count == CNT_W'(WIDTH - 1)) begin
                    word_done = 1'b1;
                    count_nxt = '0;
                    state_nxt = IDLE;
                end else begin
                    count_nxt = count + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sreg  <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            count <= count_nxt;
        end
    end

    assign busy = (state == SHIFT);

    s2p_out_reg #(
        .WIDTH(WIDTH)
    ) u_out (
        .clk          (clk),
        .rst          (rst),
        .load         (word_done),
        .word         (shifted),
        .out_ready    (out_ready),
        .clr_overflow (clr_overflow),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .overflow     (overflow)
    );

endmodule

// File: doc/serial_to_parallel_4bits.md
Name: serial_to_parallel_4bits

Overview:
Downstream companion of the team's 4-bit parallel-load shift register. It consumes that stage's MSB-first serial bit stream and reassembles WIDTH-bit words. Completed words are presented on a parallel output with a valid/ready handshake. A one-word output holding register decouples the shifter from the consumer; a sticky overflow flag reports words lost while the consumer stalls.

Parameters:
WIDTH, 4, bits per word; legal 2..16
CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not overridden)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  frame sync; marks the bit presented this cycle as the MSB of a new word
bit_in  input  1  serial data, MSB first
bit_valid  input  1  bit_in is sampled this cycle
out_data  output  WIDTH  assembled word
out_valid  output  1  out_data holds an unconsumed word
out_ready  input  1  consumer accepts out_data this cycle
busy  output  1  word assembly in progress (state SHIFT)
overflow  output  1  sticky; a completed word was dropped
clr_overflow  input  1  synchronous clear of overflow

Behaviour:
- Reset (async, immediate): state=IDLE, shift reg=0, count=0, out_data=0, out_valid=0, overflow=0, busy=0.
- A bit is accepted only in cycles with bit_valid=1. bit_in is ignored when bit_valid=0. start without bit_valid is ignored.
- Shift rule: sreg <= {sreg[WIDTH-2:0], bit_in}. The first accepted bit ends up in out_data[WIDTH-1].
- IDLE state:
  - Only start&bit_valid has effect. It loads sreg with {0.., bit_in}, sets count=1 and moves to SHIFT.
  - Plain bit_valid without start is discarded.
- SHIFT state:
  - Each bit_valid shifts and increments count.
  - start&bit_valid while in SHIFT (resync) discards the partial word, restarts with count=1 using this bit, and stays in SHIFT. No overflow is flagged.
  - On the cycle the WIDTH-th bit is accepted (count==WIDTH-1 before the edge):
    - the word {sreg[WIDTH-2:0], bit_in} is the completed word;
    - count returns to 0 and state returns to IDLE.
  - Consecutive words therefore each need their own start.
- Completed-word handoff, evaluated on the completion cycle:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: out_data <= word and out_valid <= 1. Zero bubble, and the old word counts as consumed.
  - If out_valid=1 and out_ready=0: the word is dropped, out_data is unchanged and overflow <= 1.
- Output handshake:
  - Transfer occurs when out_valid&out_ready.
  - With no new completion in that cycle, out_valid <= 0 next cycle. out_data keeps its last value.
  - out_data is stable while out_valid=1 and out_ready=0.
- Latency: out_valid rises on the clock edge that samples the last bit, i.e. it is visible the cycle after the last bit is presented.
- overflow:
  - Set as above.
  - Cleared by clr_overflow=1. If set and clear occur in the same cycle, set wins.
- busy = (state==SHIFT). It is registered-state derived, with no combinational path from inputs.
- Gaps: bit_valid may drop for any number of cycles mid-word. There is no timeout.
- Reset mid-word or with out_valid=1: everything returns to reset values immediately and the pending word is lost.

Decomposition:
- Shared package s2p_pkg: state enum (IDLE, SHIFT) and the WIDTH default constant, reused by the serializer/deserializer pair.
- One natural sub-module: s2p_out_reg. It is the one-word holding register with the valid/ready handshake and overflow logic, reusable behind other shifters.
- The shifter, counter and FSM stay in the top module.

Test Plan:
1. After reset, drive start=1 with bits 1,0,1,1 on consecutive cycles (bit_valid=1) and hold out_ready=1 -> out_data=4'b1011 and out_valid=1 for exactly 1 cycle, starting the cycle after the 4th bit; busy is high for 3 cycles.
2. Send word 4'b1100 with out_ready=0, then word 4'b0011 -> out_data stays 4'b1100, overflow=1; raise out_ready -> one transfer of 1100; pulse clr_overflow -> overflow=0.
3. Send bits 1,0 then start with bits 0,1,1,0 -> only 4'b0110 is produced and overflow stays 0.
4. Interleave bit_valid gaps of 0, 1 and 3 cycles within the word 4'b1001 -> out_data=4'b1001. Bits presented with bit_valid=0 are ignored, and bits in IDLE without start are discarded.
5. Back-to-back words 4'b1111 then 4'b0001 with out_ready asserted exactly on the completion cycle of the second -> both are delivered, out_valid remains 1 continuously, and there is no overflow.
6. Assert rst asynchronously after 2 bits and again while out_valid=1 -> all outputs are 0 immediately (before the next edge), and a following clean word 4'b0101 is received correctly.
